// File: rtl/car_input_ctrl.sv
// -----------------------------------------------------------------------------
// car_input_ctrl
//   Per-frame vehicle dynamics for the player car. A registered HID keycode
//   drives speed, steering, gear and a motion-state indication. All state
//   advances only on frame_tick, so motion is locked to the frame rate.
//
// Ports
//   Clk         in   1   system clock
//   Reset       in   1   synchronous, active-high; dominates everything
//   frame_tick  in   1   one-cycle pulse per frame
//   keycode     in   8   HID usage code (0x00 = no key)
//   speed       out  8   current speed, 0..cap
//   car_x       out 10   horizontal position, X_MIN..X_MAX
//   gear        out  1   0 = low, 1 = high
//   car_state   out  2   0 IDLE, 1 ACCEL, 2 COAST, 3 BRAKE
//
// Build option
//   CAR_AUTO_CENTER_EN : when defined, car_x drifts 1 px/frame toward X_INIT
//                        on moving frames without steering input.
// -----------------------------------------------------------------------------
module car_input_ctrl #(
   parameter int unsigned MAX_SPEED   = 200,
   parameter int unsigned ACCEL       = 2,
   parameter int unsigned BRAKE       = 6,
   parameter int unsigned DRAG        = 1,
   parameter int unsigned X_MIN       = 160,
   parameter int unsigned X_MAX       = 480,
   parameter int unsigned X_INIT      = 320,
   parameter int unsigned HOLD_FRAMES = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [7:0] keycode,
   output logic [7:0] speed,
   output logic [9:0] car_x,
   output logic       gear,
   output logic [1:0] car_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCEL = 2'd1,
      ST_COAST = 2'd2,
      ST_BRAKE = 2'd3
   } state_e;

   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_SPACE = 8'h2C;

   localparam logic [8:0] CAP_HI = 9'(MAX_SPEED);
   localparam logic [8:0] CAP_LO = 9'(MAX_SPEED >> 1);
   localparam logic [8:0] ACC9   = 9'(ACCEL);
   localparam logic [8:0] BRK9   = 9'(BRAKE);
   localparam logic [8:0] DRG9   = 9'(DRAG);

   localparam logic [10:0] XMIN11 = 11'(X_MIN);
   localparam logic [10:0] XMAX11 = 11'(X_MAX);
   localparam logic [9:0]  XMIN10 = 10'(X_MIN);
   localparam logic [9:0]  XMAX10 = 10'(X_MAX);
   localparam logic [9:0]  XINIT10 = 10'(X_INIT);

   localparam int unsigned CW = $clog2(HOLD_FRAMES + 1);
   localparam logic [CW-1:0] HOLD_N = CW'(HOLD_FRAMES);

   logic [7:0]    keycode_q;
   logic [7:0]    speed_q,  speed_d;
   logic [9:0]    x_q,      x_d;
   logic          gear_q,   gear_d;
   state_e        state_q,  state_d;
   logic [CW-1:0] hold_q,   hold_d;
   logic          armed_q,  armed_d;

   logic          kw, ks, ka, kd, ksp;
   logic [8:0]    cap, spd9, sum9, nxt9;
   logic          over_cap;
   logic [10:0]   x11, step11;
   logic [CW-1:0] hold_inc;

   // Key decode and speed arithmetic (9-bit, saturating)
   always_comb begin
      kw  = (keycode_q == KEY_W);
      ks  = (keycode_q == KEY_S);
      ka  = (keycode_q == KEY_A);
      kd  = (keycode_q == KEY_D);
      ksp = (keycode_q == KEY_SPACE);

      // Cap follows the gear held before this frame; a downshift takes
      // effect on the following frame.
      cap      = gear_q ? CAP_HI : CAP_LO;
      spd9     = {1'b0, speed_q};
      sum9     = spd9 + ACC9;
      over_cap = (spd9 > cap);

      if (over_cap) begin
         // Engine braking: never drop below the new cap in one step
         nxt9 = ((spd9 - cap) >= BRK9) ? (spd9 - BRK9) : cap;
      end else if (kw) begin
         nxt9 = (sum9 > cap) ? cap : sum9;
      end else if (ks) begin
         nxt9 = (spd9 > BRK9) ? (spd9 - BRK9) : '0;
      end else begin
         nxt9 = (spd9 > DRG9) ? (spd9 - DRG9) : '0;
      end
   end

   // Frame update: speed, state, position, gear
   always_comb begin
      speed_d  = speed_q;
      state_d  = state_q;
      x_d      = x_q;
      gear_d   = gear_q;
      hold_d   = hold_q;
      armed_d  = armed_q;
      x11      = {1'b0, x_q};
      step11   = 11'd1 + 11'(speed_q[7:6]);
      hold_inc = (hold_q == HOLD_N) ? hold_q : hold_q + CW'(1);

      if (frame_tick) begin
         speed_d = 8'(nxt9);

         if ((nxt9 == '0) && !kw)   state_d = ST_IDLE;
         else if (over_cap || ks)   state_d = ST_BRAKE;
         else if (kw)               state_d = ST_ACCEL;
         else                       state_d = ST_COAST;

         // Steering uses the speed in effect at the start of the frame
         if (speed_q != '0) begin
            if (ka) begin
               x_d = (x11 < (XMIN11 + step11)) ? XMIN10 : 10'(x11 - step11);
            end else if (kd) begin
               x_d = ((x11 + step11) > XMAX11) ? XMAX10 : 10'(x11 + step11);
            end
`ifdef CAR_AUTO_CENTER_EN
            else if (x_q > XINIT10) begin
               x_d = x_q - 10'd1;
            end else if (x_q < XINIT10) begin
               x_d = x_q + 10'd1;
            end
`endif
         end

         // Counter saturates at HOLD_N; armed blocks a second toggle
         // until space is released for a frame.
         if (ksp) begin
            hold_d = hold_inc;
            if ((hold_inc == HOLD_N) && armed_q) begin
               gear_d  = ~gear_q;
               armed_d = 1'b0;
            end
         end else begin
            hold_d  = '0;
            armed_d = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         keycode_q <= '0;
         speed_q   <= '0;
         x_q       <= XINIT10;
         gear_q    <= 1'b0;
         state_q   <= ST_IDLE;
         hold_q    <= '0;
         armed_q   <= 1'b1;
      end else begin
         keycode_q <= keycode;
         speed_q   <= speed_d;
         x_q       <= x_d;
         gear_q    <= gear_d;
         state_q   <= state_d;
         hold_q    <= hold_d;
         armed_q   <= armed_d;
      end
   end

   assign speed     = speed_q;
   assign car_x     = x_q;
   assign gear      = gear_q;
   assign car_state = state_q;

endmodule

// File: tb/tb_car_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_car_input_ctrl
//   Directed table of {key, frame count, expected outputs}, a few hand-written
//   corner sequences, then randomized keys/ticks/resets checked every cycle
//   against a frame-level behavioural model.
// -----------------------------------------------------------------------------
module tb_car_input_ctrl;

   localparam int MAXS  = 200;
   localparam int ACC   = 2;
   localparam int BRK   = 6;
   localparam int DRG   = 1;
   localparam int XMIN  = 160;
   localparam int XMAX  = 480;
   localparam int XINIT = 320;
   localparam int HOLDN = 4;
`ifdef CAR_AUTO_CENTER_EN
   localparam int AC = 1;
`else
   localparam int AC = 0;
`endif

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic [7:0] speed;
   logic [9:0] car_x;
   logic       gear;
   logic [1:0] car_state;

   car_input_ctrl #(
      .MAX_SPEED(MAXS), .ACCEL(ACC), .BRAKE(BRK), .DRAG(DRG),
      .X_MIN(XMIN), .X_MAX(XMAX), .X_INIT(XINIT), .HOLD_FRAMES(HOLDN)
   ) dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
      .speed(speed), .car_x(car_x), .gear(gear), .car_state(car_state)
   );

   always #10 Clk = ~Clk;

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;

   // ---------------- behavioural reference model ----------------
   int m_spd = 0, m_x = XINIT, m_gear = 0, m_st = 0, m_hold = 0, m_armed = 1;
   int m_key = 0;

   function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction
   function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction

   task automatic model_frame();
      int cap, ns, step;
      bit w, s, a, d, sp, eb;
      w  = (m_key == 'h1A); s = (m_key == 'h16);
      a  = (m_key == 'h04); d = (m_key == 'h07); sp = (m_key == 'h2C);
      cap = m_gear ? MAXS : MAXS / 2;
      eb  = (m_spd > cap);
      if (eb)     ns = imax(m_spd - BRK, cap);
      else if (w) ns = imin(m_spd + ACC, cap);
      else if (s) ns = imax(m_spd - BRK, 0);
      else        ns = imax(m_spd - DRG, 0);

      if (ns == 0 && !w) m_st = 0;
      else if (eb || s)  m_st = 3;
      else if (w)        m_st = 1;
      else               m_st = 2;

      if (m_spd != 0) begin
         step = 1 + m_spd / 64;
         if (a)      m_x = imax(m_x - step, XMIN);
         else if (d) m_x = imin(m_x + step, XMAX);
         else if (AC == 1) begin
            if (m_x > XINIT) m_x = m_x - 1;
            else if (m_x < XINIT) m_x = m_x + 1;
         end
      end

      if (sp) begin
         m_hold = imin(m_hold + 1, HOLDN);
         if (m_hold == HOLDN && m_armed == 1) begin
            m_gear  = 1 - m_gear;
            m_armed = 0;
         end
      end else begin
         m_hold  = 0;
         m_armed = 1;
      end
      m_spd = ns;
   endtask

   initial begin
      bit r, t;
      int k;
      forever begin
         @(posedge Clk);
         r = Reset; t = frame_tick; k = int'(keycode);
         if (r) begin
            m_spd = 0; m_x = XINIT; m_gear = 0; m_st = 0;
            m_hold = 0; m_armed = 1; m_key = 0;
         end else begin
            if (t) model_frame();
            m_key = k;
         end
         #1;
         if (mon_en) begin
            total++;
            if (int'(speed) != m_spd || int'(car_x) != m_x ||
                int'(gear) != m_gear || int'(car_state) != m_st) begin
               bad++;
               $display("FAIL model t=%0t: got spd=%0d x=%0d g=%0d st=%0d, want spd=%0d x=%0d g=%0d st=%0d",
                        $time, speed, car_x, gear, car_state, m_spd, m_x, m_gear, m_st);
            end
         end
      end
   end

   // ---------------- directed helpers ----------------
   typedef struct {
      logic [7:0] key;
      int         n;
      int         spd;
      int         x;
      int         g;
      int         st;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [7:0] k, input int n, input int s, input int x,
                      input int g, input int st);
      vec_t v;
      v.key = k; v.n = n; v.spd = s; v.x = x; v.g = g; v.st = st;
      tbl.push_back(v);
   endtask

   // Present key, let it register for one cycle, then n back-to-back ticks
   task automatic apply(input logic [7:0] k, input int n);
      @(negedge Clk);
      keycode = k;
      frame_tick = 1'b0;
      @(negedge Clk);
      frame_tick = 1'b1;
      repeat (n) @(negedge Clk);
      frame_tick = 1'b0;
   endtask

   task automatic check(input string name, input int s, input int x, input int g, input int st);
      total++;
      if (int'(speed) != s || int'(car_x) != x || int'(gear) != g || int'(car_state) != st) begin
         bad++;
         $display("FAIL %s: got spd=%0d x=%0d g=%0d st=%0d, want spd=%0d x=%0d g=%0d st=%0d",
                  name, speed, car_x, gear, car_state, s, x, g, st);
      end
   endtask

   function automatic logic [7:0] pick_key();
      case ($urandom_range(9))
         0, 1, 2: return 8'h1A;
         3:       return 8'h16;
         4:       return 8'h04;
         5:       return 8'h07;
         6:       return 8'h2C;
         7:       return 8'h00;
         8:       return 8'h55;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      // key, ticks, speed, x, gear, state
      add(8'h1A, 50, 100, 320, 0, 1);   // accelerate to low cap
      add(8'h1A, 10, 100, 320, 0, 1);   // hold at low cap
      add(8'h2C,  3,  97, 320, 0, 2);   // space not yet long enough
      add(8'h2C,  1,  96, 320, 1, 2);   // 4th frame: upshift
      add(8'h2C, 20,  76, 320, 1, 2);   // held: no second toggle
      add(8'h1A, 52, 180, 320, 1, 1);
      add(8'h2C,  4, 176, 320, 0, 2);   // downshift at 180
      add(8'h00,  1, 170, 320, 0, 3);   // engine braking
      add(8'h00, 11, 104, 320, 0, 3);
      add(8'h00,  1, 100, 320, 0, 3);   // lands exactly on cap
      add(8'h00,  1,  99, 320, 0, 2);   // then coasts
      add(8'h16, 16,   3, 320, 0, 3);
      add(8'h16,  1,   0, 320, 0, 0);   // brake to zero -> IDLE
      add(8'h04,  3,   0, 320, 0, 0);   // no steering at rest
      add(8'h1A, 40,  80, 320, 0, 1);
      add(8'h55,  2,  78, 320, 0, 2);   // unknown key coasts
      add(8'h07,  1,  77, 322, 0, 2);   // step 2 at speed 78
      add(8'h04,  1,  76, 320, 0, 2);
      add(8'h2C,  4,  72, 320, 1, 2);
      add(8'h1A, 64, 200, 320, 1, 1);   // high cap
      add(8'h1A,  5, 200, 320, 1, 1);
      add(8'h07, 200,  0, 480, 1, 0);   // steer into right clamp
      add(8'h07,  3,   0, 480, 1, 0);
      add(8'h1A, 60, 120, 480 - 59 * AC, 1, 1);

      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      mon_en = 1'b1;
      check("reset", 0, XINIT, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].key, tbl[i].n);
         check($sformatf("vec%0d", i), tbl[i].spd, tbl[i].x, tbl[i].g, tbl[i].st);
      end

      // Reset coincident with a frame tick while moving
      @(negedge Clk);
      Reset = 1'b1;
      frame_tick = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      frame_tick = 1'b0;
      check("reset_on_tick", 0, XINIT, 0, 0);

      // Outputs hold between ticks
      repeat (5) @(negedge Clk);
      check("hold_no_tick", 0, XINIT, 0, 0);

      // Auto-centre behaviour (or hold without the option)
      apply(8'h1A, 25);
      check("ac_speed50", 50, 320, 0, 1);
      apply(8'h07, 10);
      check("ac_x330", 40, 330, 0, 2);
      apply(8'h00, 10);
      check("ac_drift", 30, (AC == 1) ? 320 : 330, 0, 2);
      apply(8'h00, 5);
      check("ac_settle", 25, (AC == 1) ? 320 : 330, 0, 2);

      // Randomized phase, checked by the model every cycle
      for (int c = 0; c < 4000; c++) begin
         @(negedge Clk);
         if ($urandom_range(7) == 0) keycode = pick_key();
         frame_tick = ($urandom_range(2) == 0);
         Reset = ($urandom_range(599) == 0);
      end
      @(negedge Clk);
      Reset = 1'b0;
      frame_tick = 1'b0;
      repeat (2) @(negedge Clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
